// File: rtl/riscv_mc_ctrl.sv
// riscv_mc_ctrl: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I core.
// Shares one memory port between fetch and load/store and gates the decoder's strobes.
// Optional cycle/instret counters are built when RISCV_MC_PERF_EN is defined.
module riscv_mc_ctrl #(
  parameter int unsigned WAIT_MAX = 16,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [6:0]       i_mc_opcode,
  input  logic [1:0]       i_mc_dec_src_pc,
  input  logic             i_mc_dec_reg_wr_en,
  input  logic             i_mc_dec_mem_wr_en,
  input  logic             i_mc_mem_ready,
  output logic             o_mc_mem_req,
  output logic             o_mc_mem_src,
  output logic             o_mc_mem_wr_en,
  output logic             o_mc_ir_wr_en,
  output logic             o_mc_pc_wr_en,
  output logic [1:0]       o_mc_pc_src,
  output logic             o_mc_reg_wr_en,
  output logic             o_mc_retire,
  output logic [2:0]       o_mc_state,
`ifdef RISCV_MC_PERF_EN
  output logic [CNT_W-1:0] o_mc_cycle_cnt,
  output logic [CNT_W-1:0] o_mc_instret_cnt,
`endif
  output logic             o_mc_err
);

  localparam int unsigned WAIT_W = $clog2(WAIT_MAX);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_ERR    = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d, wait_inc;
  logic              err_q, err_d;

  logic is_load, is_store, is_branch, opc_legal;
  logic mem_req, mem_src, mem_wr, ir_wr, pc_wr, reg_wr, retire;

  // Classify the opcode held in IR; only the nine RV32I base opcodes are legal.
  always_comb begin
    is_load   = (i_mc_opcode == OPC_LOAD);
    is_store  = (i_mc_opcode == OPC_STORE);
    is_branch = (i_mc_opcode == OPC_BRANCH);
    case (i_mc_opcode)
      OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH,
      OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC: opc_legal = 1'b1;
      default:                               opc_legal = 1'b0;
    endcase
  end

  // Next-state, wait-counter and per-state strobe generation.
  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    err_d    = err_q;
    wait_inc = wait_q + 1'b1;
    mem_req  = 1'b0;
    mem_src  = 1'b0;
    mem_wr   = 1'b0;
    ir_wr    = 1'b0;
    pc_wr    = 1'b0;
    reg_wr   = 1'b0;
    retire   = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (i_mc_mem_ready) begin
          ir_wr   = 1'b1;
          wait_d  = '0;
          state_d = S_DECODE;
        end else if (wait_inc == WAIT_LAST) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_inc;
        end
      end
      S_DECODE: begin
        if (opc_legal) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end
      end
      S_EXEC: begin
        wait_d = '0;
        if (is_branch) begin
          pc_wr   = 1'b1;
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (is_load || is_store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_src = 1'b1;
        mem_wr  = is_store & i_mc_dec_mem_wr_en;
        if (i_mc_mem_ready) begin
          wait_d = '0;
          if (is_store) begin
            pc_wr   = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_inc == WAIT_LAST) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_inc;
        end
      end
      S_WB: begin
        reg_wr  = i_mc_dec_reg_wr_en;
        pc_wr   = 1'b1;
        retire  = 1'b1;
        wait_d  = '0;
        state_d = S_FETCH;
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: begin
        state_d = S_ERR;
        err_d   = 1'b1;
      end
    endcase
  end

  // Sequencer state, wait counter and sticky error flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  // Strobes are forced low while reset is held so nothing leaks out mid-reset.
  assign o_mc_mem_req   = mem_req & ~i_rst;
  assign o_mc_mem_src   = mem_src;
  assign o_mc_mem_wr_en = mem_wr & ~i_rst;
  assign o_mc_ir_wr_en  = ir_wr & ~i_rst;
  assign o_mc_pc_wr_en  = pc_wr & ~i_rst;
  assign o_mc_pc_src    = o_mc_pc_wr_en ? i_mc_dec_src_pc : 2'b00;
  assign o_mc_reg_wr_en = reg_wr & ~i_rst;
  assign o_mc_retire    = retire & ~i_rst;
  assign o_mc_state     = state_q;
  assign o_mc_err       = err_q;

`ifdef RISCV_MC_PERF_EN
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d, instret_cnt_q, instret_cnt_d;

  // Counters advance outside ERR only, so a dead core keeps its last totals.
  always_comb begin
    cycle_cnt_d   = cycle_cnt_q;
    instret_cnt_d = instret_cnt_q;
    if (state_q != S_ERR) begin
      cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
      if (retire) begin
        instret_cnt_d = instret_cnt_q + CNT_W'(1);
      end
    end
  end

  // Performance counter registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else begin
      cycle_cnt_q   <= cycle_cnt_d;
      instret_cnt_q <= instret_cnt_d;
    end
  end

  assign o_mc_cycle_cnt   = cycle_cnt_q;
  assign o_mc_instret_cnt = instret_cnt_q;
`endif

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// tb_riscv_mc_ctrl: self-checking bench for the multi-cycle sequencer.
// Each instruction is expanded into an expected cycle-by-cycle trace from its
// class and its memory wait counts, then played against the DUT.
module tb_riscv_mc_ctrl;

  localparam int WAIT_MAX = 16;
  localparam int CNT_W    = 32;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] ST_FETCH = 3'd0, ST_DECODE = 3'd1, ST_EXEC = 3'd2;
  localparam logic [2:0] ST_MEM = 3'd3, ST_WB = 3'd4, ST_ERR = 3'd5;

  logic [6:0] legal_ops [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                                7'b0010111};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] op = '0;
  logic [1:0] spc = '0;
  logic       drw = 1'b0, dmw = 1'b0, ready = 1'b0;
  logic       mem_req, mem_src, mem_wr, ir_wr, pc_wr, reg_wr, retire, err;
  logic [1:0] pc_src;
  logic [2:0] state;
`ifdef RISCV_MC_PERF_EN
  logic [CNT_W-1:0] cycle_cnt, instret_cnt;
  int unsigned model_cycles = 0, model_instret = 0;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  riscv_mc_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_mc_opcode(op),
    .i_mc_dec_src_pc(spc),
    .i_mc_dec_reg_wr_en(drw),
    .i_mc_dec_mem_wr_en(dmw),
    .i_mc_mem_ready(ready),
    .o_mc_mem_req(mem_req),
    .o_mc_mem_src(mem_src),
    .o_mc_mem_wr_en(mem_wr),
    .o_mc_ir_wr_en(ir_wr),
    .o_mc_pc_wr_en(pc_wr),
    .o_mc_pc_src(pc_src),
    .o_mc_reg_wr_en(reg_wr),
    .o_mc_retire(retire),
    .o_mc_state(state),
`ifdef RISCV_MC_PERF_EN
    .o_mc_cycle_cnt(cycle_cnt),
    .o_mc_instret_cnt(instret_cnt),
`endif
    .o_mc_err(err)
  );

  // One expected cycle: what to drive on ready plus every expected output.
  typedef struct packed {
    logic       rdy;
    logic [2:0] st;
    logic       req, src, mwr, irw, pcw;
    logic [1:0] pcs;
    logic       rgw, ret, er;
    logic [6:0] op;
    logic [1:0] spc;
    logic       drw, dmw;
  } exp_t;

  exp_t       trace[$];
  bit         need_reset = 0;
  logic [6:0] cur_op;
  logic [1:0] cur_spc;
  logic       cur_drw, cur_dmw;

  // Every comparison in the bench funnels through here.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h t=%0t", tag, observed, expected, $time);
    end
  endtask

  function automatic bit isLegal(input logic [6:0] o);
    foreach (legal_ops[i]) if (legal_ops[i] == o) return 1'b1;
    return 1'b0;
  endfunction

  // Append one expected cycle for the instruction currently being expanded.
  task automatic pushCycle(input logic rdy, input logic [2:0] st, input logic req, input logic src,
                           input logic mwr, input logic irw, input logic pcw, input logic rgw,
                           input logic ret);
    exp_t e;
    e.rdy = rdy; e.st = st; e.req = req; e.src = src; e.mwr = mwr; e.irw = irw;
    e.pcw = pcw; e.pcs = pcw ? cur_spc : 2'b00; e.rgw = rgw; e.ret = ret;
    e.er = (st == ST_ERR);
    e.op = cur_op; e.spc = cur_spc; e.drw = cur_drw; e.dmw = cur_dmw;
    trace.push_back(e);
  endtask

  // A dead controller: a few cycles of random ready that must all be ignored.
  task automatic addErrTail();
    for (int i = 0; i < 3; i++)
      pushCycle(1'($urandom_range(0, 1)), ST_ERR, 0, 0, 0, 0, 0, 0, 0);
    need_reset = 1;
  endtask

  // Request with n_wait ready-low cycles; WAIT_MAX-1 of them in a row is a timeout.
  task automatic addWaits(input logic [2:0] st, input int n_wait, input logic src,
                          input logic mwr, output bit timed_out);
    timed_out = (n_wait >= WAIT_MAX - 1);
    for (int i = 0; i < n_wait && i < WAIT_MAX - 1; i++)
      pushCycle(0, st, 1, src, mwr, 0, 0, 0, 0);
    if (timed_out) addErrTail();
  endtask

  // Expand one instruction into its expected trace from its class and wait counts.
  task automatic buildInstr(input logic [6:0] o, input logic [1:0] s, input logic rw,
                            input logic mw, input int nf, input int nm);
    bit to;
    cur_op = o; cur_spc = s; cur_drw = rw; cur_dmw = mw;
    addWaits(ST_FETCH, nf, 0, 0, to);
    if (to) return;
    pushCycle(1, ST_FETCH, 1, 0, 0, 1, 0, 0, 0);
    pushCycle(1'($urandom_range(0, 1)), ST_DECODE, 0, 0, 0, 0, 0, 0, 0);
    if (!isLegal(o)) begin
      addErrTail();
      return;
    end
    if (o == OPC_BRANCH) begin
      pushCycle(1'($urandom_range(0, 1)), ST_EXEC, 0, 0, 0, 0, 1, 0, 1);
      return;
    end
    pushCycle(1'($urandom_range(0, 1)), ST_EXEC, 0, 0, 0, 0, 0, 0, 0);
    if (o == OPC_LOAD || o == OPC_STORE) begin
      addWaits(ST_MEM, nm, 1, (o == OPC_STORE) & mw, to);
      if (to) return;
      if (o == OPC_STORE) begin
        pushCycle(1, ST_MEM, 1, 1, mw, 0, 1, 0, 1);
        return;
      end
      pushCycle(1, ST_MEM, 1, 1, 0, 0, 0, 0, 0);
    end
    pushCycle(1'($urandom_range(0, 1)), ST_WB, 0, 0, 0, 0, 1, rw, 1);
  endtask

  // One synchronous reset cycle; every strobe must stay low while it is held.
  task automatic doReset();
    @(negedge clk);
    rst = 1'b1; ready = 1'($urandom); op = 7'($urandom); spc = 2'($urandom);
    drw = 1'($urandom); dmw = 1'b1;
    #1;
    checkOutput("rst.mem_req", {31'b0, mem_req}, 0);
    checkOutput("rst.mem_wr", {31'b0, mem_wr}, 0);
    checkOutput("rst.ir_wr", {31'b0, ir_wr}, 0);
    checkOutput("rst.pc_wr", {31'b0, pc_wr}, 0);
    checkOutput("rst.reg_wr", {31'b0, reg_wr}, 0);
    checkOutput("rst.retire", {31'b0, retire}, 0);
`ifdef RISCV_MC_PERF_EN
    model_cycles = 0; model_instret = 0;
`endif
  endtask

  // Play the first 'cut' cycles of the trace; a cut trace or an error ends in reset.
  task automatic applyStimulus(input int cut);
    int n;
    exp_t e;
    n = (cut < trace.size()) ? cut : trace.size();
    for (int i = 0; i < n; i++) begin
      e = trace[i];
      @(negedge clk);
      rst = 1'b0; ready = e.rdy;
      if (e.st == ST_FETCH || e.st == ST_ERR) begin
        op = 7'($urandom); spc = 2'($urandom); drw = 1'($urandom); dmw = 1'($urandom);
      end else begin
        op = e.op; spc = e.spc; drw = e.drw; dmw = e.dmw;
      end
      #1;
      cyc++;
      checkOutput($sformatf("c%0d.state", cyc), {29'b0, state}, {29'b0, e.st});
      checkOutput($sformatf("c%0d.err", cyc), {31'b0, err}, {31'b0, e.er});
      checkOutput($sformatf("c%0d.mem_req", cyc), {31'b0, mem_req}, {31'b0, e.req});
      if (e.req) checkOutput($sformatf("c%0d.mem_src", cyc), {31'b0, mem_src}, {31'b0, e.src});
      checkOutput($sformatf("c%0d.mem_wr", cyc), {31'b0, mem_wr}, {31'b0, e.mwr});
      checkOutput($sformatf("c%0d.ir_wr", cyc), {31'b0, ir_wr}, {31'b0, e.irw});
      checkOutput($sformatf("c%0d.pc_wr", cyc), {31'b0, pc_wr}, {31'b0, e.pcw});
      checkOutput($sformatf("c%0d.pc_src", cyc), {30'b0, pc_src}, {30'b0, e.pcs});
      checkOutput($sformatf("c%0d.reg_wr", cyc), {31'b0, reg_wr}, {31'b0, e.rgw});
      checkOutput($sformatf("c%0d.retire", cyc), {31'b0, retire}, {31'b0, e.ret});
`ifdef RISCV_MC_PERF_EN
      checkOutput($sformatf("c%0d.cycle_cnt", cyc), cycle_cnt, model_cycles);
      checkOutput($sformatf("c%0d.instret_cnt", cyc), instret_cnt, model_instret);
      if (e.st != ST_ERR) model_cycles++;
      if (e.ret) model_instret++;
`endif
    end
    if (n < trace.size() || need_reset) doReset();
    trace.delete();
    need_reset = 0;
  endtask

  function automatic logic [6:0] randomOp();
    logic [6:0] o;
    if ($urandom_range(0, 99) < 90) return legal_ops[$urandom_range(0, 8)];
    do o = 7'($urandom); while (isLegal(o));
    return o;
  endfunction

  function automatic int randomWait();
    int r;
    r = $urandom_range(0, 99);
    if (r < 2) return WAIT_MAX - 1;
    if (r < 4) return WAIT_MAX - 2;
    if (r < 60) return 0;
    return $urandom_range(1, 4);
  endfunction

  // Directed scenarios first, then a randomized instruction stream.
  initial begin
    doReset();
    doReset();
    $display("[TB] directed scenarios");
    buildInstr(OPC_OP_IMM, 2'd0, 1, 0, 0, 0);            applyStimulus(1000);
    buildInstr(OPC_LOAD,   2'd0, 1, 0, 0, 3);            applyStimulus(1000);
    buildInstr(OPC_STORE,  2'd0, 1, 1, 0, 0);            applyStimulus(1000);
    buildInstr(OPC_BRANCH, 2'd1, 1, 1, 0, 0);            applyStimulus(1000);
    buildInstr(7'b0000000, 2'd0, 1, 1, 0, 0);            applyStimulus(1000);
    buildInstr(OPC_OP_IMM, 2'd2, 1, 0, WAIT_MAX - 1, 0); applyStimulus(1000);
    buildInstr(OPC_OP_IMM, 2'd2, 1, 0, WAIT_MAX - 2, 0); applyStimulus(1000);
    buildInstr(OPC_STORE,  2'd0, 0, 1, 0, 2);            applyStimulus(5);
`ifdef RISCV_MC_PERF_EN
    doReset();
    for (int i = 0; i < 10; i++) begin
      buildInstr(OPC_OP_IMM, 2'd0, 1, 0, 0, 0);
      applyStimulus(1000);
    end
    @(posedge clk);
    #1;
    checkOutput("perf.cycle_after_10", cycle_cnt, 40);
    checkOutput("perf.instret_after_10", instret_cnt, 10);
`endif
    $display("[TB] random stream");
    for (int k = 0; k < 250; k++) begin
      buildInstr(randomOp(), 2'($urandom), 1'($urandom), 1'($urandom), randomWait(), randomWait());
      if ($urandom_range(0, 99) < 6 && trace.size() > 1)
        applyStimulus($urandom_range(1, trace.size() - 1));
      else
        applyStimulus(1000);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
